// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use
// hazard detection, feeding the execute-stage ALU.
//
// Optional feature macro: ID_EX_FWD_EN
//   defined   : EX/MEM and MEM/WB results are forwarded onto the ALU operands
//               and the store data; load_use covers loads only.
//   undefined : operands come straight from the latched register data;
//               load_use covers any valid in-stage register writer; the
//               exmem_* / memwb_* ports are present but unused.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   stall, flush          downstream hold / squash to bubble (flush wins)
//   in_*                  decoded instruction from the decode stage
//   exmem_*, memwb_*      writeback sources for forwarding
//   ALU_DA, ALU_DB, ALUOp ALU operands and opcode
//   ex_*                  stage contents for later stages (control gated by ex_valid)
//   load_use, hold_up     hazard flag and upstream hold (stall | load_use)
module id_ex_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_rs_data,
  input  logic [DW-1:0] in_rt_data,
  input  logic [DW-1:0] in_imm,
  input  logic [AW-1:0] in_rs_addr,
  input  logic [AW-1:0] in_rt_addr,
  input  logic [AW-1:0] in_dst_addr,
  input  logic          in_alusrc,
  input  logic [2:0]    in_aluop,
  input  logic          in_regwrite,
  input  logic          in_memread,
  input  logic          in_memwrite,
  input  logic          in_memtoreg,
  input  logic          exmem_regwrite,
  input  logic [AW-1:0] exmem_dst,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [AW-1:0] memwb_dst,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] ALU_DA,
  output logic [DW-1:0] ALU_DB,
  output logic [2:0]    ALUOp,
  output logic          ex_valid,
  output logic [DW-1:0] ex_store_data,
  output logic [AW-1:0] ex_dst_addr,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          load_use,
  output logic          hold_up
);

  logic          valid_q;
  logic [DW-1:0] rs_data_q;
  logic [DW-1:0] rt_data_q;
  logic [DW-1:0] imm_q;
  logic [AW-1:0] rs_addr_q;
  logic [AW-1:0] rt_addr_q;
  logic [AW-1:0] dst_q;
  logic          alusrc_q;
  logic [2:0]    aluop_q;
  logic          regwrite_q;
  logic          memread_q;
  logic          memwrite_q;
  logic          memtoreg_q;

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic          hazard_writer;
  logic          src_match;

  // Stage register. Bubbles (flush / load_use) clear only valid and the
  // control bits; the data fields are don't-care and simply keep their value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      dst_q      <= '0;
      alusrc_q   <= 1'b0;
      aluop_q    <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else if (!stall) begin
      if (load_use) begin
        valid_q    <= 1'b0;
        regwrite_q <= 1'b0;
        memread_q  <= 1'b0;
        memwrite_q <= 1'b0;
        memtoreg_q <= 1'b0;
      end else begin
        valid_q    <= in_valid;
        rs_data_q  <= in_rs_data;
        rt_data_q  <= in_rt_data;
        imm_q      <= in_imm;
        rs_addr_q  <= in_rs_addr;
        rt_addr_q  <= in_rt_addr;
        dst_q      <= in_dst_addr;
        alusrc_q   <= in_alusrc;
        aluop_q    <= in_aluop;
        regwrite_q <= in_regwrite;
        memread_q  <= in_memread;
        memwrite_q <= in_memwrite;
        memtoreg_q <= in_memtoreg;
      end
    end
  end

`ifdef ID_EX_FWD_EN
  // EX/MEM is checked first so the youngest in-flight value wins.
  // Register 0 never forwards; its latched data is already 0.
  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_regwrite && (exmem_dst != '0) && (exmem_dst == rs_addr_q))
      fwd_rs = exmem_result;
    else if (memwb_regwrite && (memwb_dst != '0) && (memwb_dst == rs_addr_q))
      fwd_rs = memwb_result;
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (exmem_regwrite && (exmem_dst != '0) && (exmem_dst == rt_addr_q))
      fwd_rt = exmem_result;
    else if (memwb_regwrite && (memwb_dst != '0) && (memwb_dst == rt_addr_q))
      fwd_rt = memwb_result;
  end

  // With forwarding only a load's result is too late for the next instruction.
  assign hazard_writer = memread_q;
`else
  logic unused_fwd;

  assign fwd_rs = rs_data_q;
  assign fwd_rt = rt_data_q;
  assign unused_fwd = ^{exmem_regwrite, exmem_dst, exmem_result,
                        memwb_regwrite, memwb_dst, memwb_result,
                        rs_addr_q, rt_addr_q};

  // Without forwarding any pending register write must drain first.
  assign hazard_writer = regwrite_q;
`endif

  assign src_match = (dst_q == in_rs_addr) || (dst_q == in_rt_addr);
  assign load_use  = valid_q && hazard_writer && in_valid && (dst_q != '0) && src_match;
  assign hold_up   = stall | load_use;

  assign ALU_DA        = fwd_rs;
  assign ALU_DB        = alusrc_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ALUOp         = aluop_q;
  assign ex_valid      = valid_q;
  assign ex_dst_addr   = dst_q;
  assign ex_regwrite   = regwrite_q & valid_q;
  assign ex_memread    = memread_q  & valid_q;
  assign ex_memwrite   = memwrite_q & valid_q;
  assign ex_memtoreg   = memtoreg_q & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed stimulus for id_ex_stage, checked
// against a behavioural model of the instruction occupying the EX slot.
// Follows ID_EX_FWD_EN the same way the design does.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, flush, in_valid;
  logic [DW-1:0] in_rs_data, in_rt_data, in_imm;
  logic [AW-1:0] in_rs_addr, in_rt_addr, in_dst_addr;
  logic          in_alusrc;
  logic [2:0]    in_aluop;
  logic          in_regwrite, in_memread, in_memwrite, in_memtoreg;
  logic          exmem_regwrite, memwb_regwrite;
  logic [AW-1:0] exmem_dst, memwb_dst;
  logic [DW-1:0] exmem_result, memwb_result;
  logic [DW-1:0] ALU_DA, ALU_DB, ex_store_data;
  logic [2:0]    ALUOp;
  logic [AW-1:0] ex_dst_addr;
  logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic          load_use, hold_up;

  int checks = 0;
  int failures = 0;

  id_ex_stage #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_dst_addr(in_dst_addr),
    .in_alusrc(in_alusrc), .in_aluop(in_aluop), .in_regwrite(in_regwrite),
    .in_memread(in_memread), .in_memwrite(in_memwrite), .in_memtoreg(in_memtoreg),
    .exmem_regwrite(exmem_regwrite), .exmem_dst(exmem_dst), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_dst(memwb_dst), .memwb_result(memwb_result),
    .ALU_DA(ALU_DA), .ALU_DB(ALU_DB), .ALUOp(ALUOp), .ex_valid(ex_valid),
    .ex_store_data(ex_store_data), .ex_dst_addr(ex_dst_addr),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .load_use(load_use), .hold_up(hold_up)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // The instruction sitting in EX, as the pipeline sees it.
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic [AW-1:0] rs, rt, dst;
    logic          alusrc;
    logic [2:0]    aluop;
    logic          rw, mr, mw, mtr;
  } instr_t;

  instr_t m;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Value an instruction reading register `addr` must see.
  function automatic logic [DW-1:0] operand(input logic [AW-1:0] addr, input logic [DW-1:0] rf);
`ifdef ID_EX_FWD_EN
    if (addr != 0 && exmem_regwrite && exmem_dst == addr) return exmem_result;
    if (addr != 0 && memwb_regwrite && memwb_dst == addr) return memwb_result;
`endif
    return rf;
  endfunction

  function automatic logic exp_hazard();
    logic producer;
`ifdef ID_EX_FWD_EN
    producer = m.mr;
`else
    producer = m.rw;
`endif
    return m.valid && producer && in_valid && m.dst != 0 &&
           (m.dst == in_rs_addr || m.dst == in_rt_addr);
  endfunction

  task automatic check_outputs();
    logic lu;
    lu = exp_hazard();
    check("ex_valid", {31'b0, ex_valid}, {31'b0, m.valid});
    check("ex_regwrite", {31'b0, ex_regwrite}, {31'b0, m.valid & m.rw});
    check("ex_memread", {31'b0, ex_memread}, {31'b0, m.valid & m.mr});
    check("ex_memwrite", {31'b0, ex_memwrite}, {31'b0, m.valid & m.mw});
    check("ex_memtoreg", {31'b0, ex_memtoreg}, {31'b0, m.valid & m.mtr});
    check("load_use", {31'b0, load_use}, {31'b0, lu});
    check("hold_up", {31'b0, hold_up}, {31'b0, lu | stall});
    if (m.valid) begin
      check("ALU_DA", ALU_DA, operand(m.rs, m.rs_data));
      check("ALU_DB", ALU_DB, m.alusrc ? m.imm : operand(m.rt, m.rt_data));
      check("ex_store_data", ex_store_data, operand(m.rt, m.rt_data));
      check("ALUOp", {29'b0, ALUOp}, {29'b0, m.aluop});
      check("ex_dst_addr", {27'b0, ex_dst_addr}, {27'b0, m.dst});
    end
  endtask

  task automatic advance();
    if (flush) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.mtr = 0;
    end else if (stall) begin
      // instruction stays put
    end else if (exp_hazard()) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.mtr = 0;
    end else begin
      m.valid = in_valid; m.rs_data = in_rs_data; m.rt_data = in_rt_data;
      m.imm = in_imm; m.rs = in_rs_addr; m.rt = in_rt_addr; m.dst = in_dst_addr;
      m.alusrc = in_alusrc; m.aluop = in_aluop; m.rw = in_regwrite;
      m.mr = in_memread; m.mw = in_memwrite; m.mtr = in_memtoreg;
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    #1 check_outputs();
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic clear_in();
    stall = 0; flush = 0; in_valid = 0;
    in_rs_data = '0; in_rt_data = '0; in_imm = '0;
    in_rs_addr = '0; in_rt_addr = '0; in_dst_addr = '0;
    in_alusrc = 0; in_aluop = '0;
    in_regwrite = 0; in_memread = 0; in_memwrite = 0; in_memtoreg = 0;
    exmem_regwrite = 0; exmem_dst = '0; exmem_result = '0;
    memwb_regwrite = 0; memwb_dst = '0; memwb_result = '0;
  endtask

  task automatic rand_in();
    logic [2:0] ops [5];
    ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    stall = ($urandom_range(0, 5) == 0);
    flush = ($urandom_range(0, 9) == 0);
    in_valid = ($urandom_range(0, 3) != 0);
    in_rs_data = $urandom; in_rt_data = $urandom; in_imm = $urandom;
    in_rs_addr = AW'($urandom_range(0, 3));
    in_rt_addr = AW'($urandom_range(0, 3));
    in_dst_addr = AW'($urandom_range(0, 3));
    in_alusrc = 1'($urandom);
    in_aluop = ops[$urandom_range(0, 4)];
    in_regwrite = 1'($urandom); in_memread = 1'($urandom);
    in_memwrite = 1'($urandom); in_memtoreg = 1'($urandom);
    exmem_regwrite = 1'($urandom); exmem_dst = AW'($urandom_range(0, 3));
    exmem_result = $urandom;
    memwb_regwrite = 1'($urandom); memwb_dst = AW'($urandom_range(0, 3));
    memwb_result = $urandom;
  endtask

  initial begin
    m = '0;
    clear_in();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset ex_valid", {31'b0, ex_valid}, 32'd0);
    check("reset ALUOp", {29'b0, ALUOp}, 32'd0);
    check("reset ALU_DA", ALU_DA, 32'd0);
    check("reset ALU_DB", ALU_DB, 32'd0);
    check("reset load_use", {31'b0, load_use}, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Plain capture: rs=5, rt=7.
    in_valid = 1; in_rs_addr = 1; in_rt_addr = 2; in_dst_addr = 3;
    in_rs_data = 5; in_rt_data = 7; in_regwrite = 1;
    step();
    clear_in();
    #1 check("capture ALU_DA", ALU_DA, 32'd5);
    check("capture ALU_DB", ALU_DB, 32'd7);
    step();

    // rs=3 with both writeback stages targeting it; EX/MEM is newer.
    in_valid = 1; in_rs_addr = 3; in_rs_data = 32'h1; in_dst_addr = 6;
    step();
    clear_in();
    exmem_regwrite = 1; exmem_dst = 3; exmem_result = 32'h10;
    memwb_regwrite = 1; memwb_dst = 3; memwb_result = 32'h20;
    step();

    // Writer to register 0 must not reach a $0 operand.
    clear_in();
    in_valid = 1; in_rs_addr = 0; in_rs_data = 0;
    step();
    clear_in();
    exmem_regwrite = 1; exmem_dst = 0; exmem_result = 32'hFF;
    #1 check("zero-reg ALU_DA", ALU_DA, 32'd0);
    step();

    // lw $4 followed by a reader of $4.
    clear_in();
    in_valid = 1; in_dst_addr = 4; in_memread = 1; in_regwrite = 1; in_memtoreg = 1;
    step();
    in_memread = 0; in_memtoreg = 0; in_regwrite = 1; in_dst_addr = 7;
    in_rs_addr = 4;
    #1 check("load_use asserted", {31'b0, load_use}, 32'd1);
    check("hold_up asserted", {31'b0, hold_up}, 32'd1);
    step();
    clear_in();
    step();

    // Stall holds rs=9 for three cycles, then stall+flush squashes.
    in_valid = 1; in_rs_addr = 5; in_rs_data = 9; in_aluop = 3'b101;
    step();
    clear_in();
    stall = 1;
    repeat (3) begin
      #1 check("stall ALU_DA", ALU_DA, 32'd9);
      step();
    end
    stall = 1; flush = 1;
    step();
    clear_in();
    step();

    // Immediate select with rt forwarded to 0x44.
    in_valid = 1; in_alusrc = 1; in_imm = 32'hFFFF_FFFC;
    in_rt_addr = 6; in_rt_data = 32'h1; in_memwrite = 1;
    step();
    clear_in();
    exmem_regwrite = 1; exmem_dst = 6; exmem_result = 32'h44;
    #1 check("imm ALU_DB", ALU_DB, 32'hFFFF_FFFC);
    step();

    // Random traffic with frequent address collisions.
    for (int i = 0; i < 400; i++) begin
      rand_in();
      step();
    end

    // Asynchronous reset while a hazard is pending and stall is held.
    clear_in();
    in_valid = 1; in_dst_addr = 2; in_memread = 1; in_regwrite = 1;
    step();
    in_rs_addr = 2; stall = 1;
    #1 check("pre-reset load_use", {31'b0, load_use}, 32'd1);
    #2 rst_n = 0;
    m = '0;
    #1 check_outputs();
    @(negedge clk);
    rst_n = 1;
    step();
    clear_in();
    step();

    for (int i = 0; i < 200; i++) begin
      rand_in();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
